// File: rtl/layer1_sequencer_pkg.sv
// layer1_sequencer_pkg
//   Shared constants and state encoding for the layer-1 datapath
//   (sequencer, accumulator, bias/activation stages).
package layer1_sequencer_pkg;

    localparam int NPIXEL     = 784;  // pixels per image = products per neuron
    localparam int NNEURON    = 10;   // hidden neurons in layer 1
    localparam int COUNT_BIT1 = 10;   // pixel index width
    localparam int NEURON_BIT = 4;    // neuron index width
    localparam int WADDR_BITS = 14;   // weight address width
    localparam int TIMEOUT    = 16;   // max cycles waited for add_bias

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_RUN   = 3'd1,
        S_WAIT  = 3'd2,
        S_STORE = 3'd3,
        S_DONE  = 3'd4
    } seq_state_t;

endpackage

// File: rtl/layer1_sequencer_addr_gen.sv
// seq_addr_gen
//   Pixel / weight read-address counters and the product-valid qualifier.
//   Ports:
//     clk, reset_b    clock, async active-low reset
//     clear           load both counters with 0 (image start)
//     step            advance pixel and weight address by one
//     next_row        begin next neuron: pixel back to 0, weight address +1
//     issue           an address is being issued this cycle
//     pixel_addr      pixel buffer read address
//     weight_addr     weight memory read address (running, row-major)
//     start_multiply  issue delayed one cycle to match 1-cycle read latency
//     last_pix        pixel_addr is the final pixel of the row
module seq_addr_gen #(
    parameter int NPIXEL     = layer1_sequencer_pkg::NPIXEL,
    parameter int COUNT_BIT1 = layer1_sequencer_pkg::COUNT_BIT1,
    parameter int WADDR_BITS = layer1_sequencer_pkg::WADDR_BITS
) (
    input  logic                  clk,
    input  logic                  reset_b,
    input  logic                  clear,
    input  logic                  step,
    input  logic                  next_row,
    input  logic                  issue,
    output logic [COUNT_BIT1-1:0] pixel_addr,
    output logic [WADDR_BITS-1:0] weight_addr,
    output logic                  start_multiply,
    output logic                  last_pix
);
    import layer1_sequencer_pkg::*;

    assign last_pix = (pixel_addr == COUNT_BIT1'(NPIXEL - 1));

    // The last address of a row is held through WAIT/STORE; the wrap to
    // pixel 0 and the weight advance happen on re-entry to RUN, so both
    // addresses keep their last value outside RUN.
    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            pixel_addr     <= '0;
            weight_addr    <= '0;
            start_multiply <= 1'b0;
        end else begin
            start_multiply <= issue;
            if (clear) begin
                pixel_addr  <= '0;
                weight_addr <= '0;
            end else if (step) begin
                pixel_addr  <= pixel_addr + COUNT_BIT1'(1);
                weight_addr <= weight_addr + WADDR_BITS'(1);
            end else if (next_row) begin
                pixel_addr  <= '0;
                weight_addr <= weight_addr + WADDR_BITS'(1);
            end
        end
    end

endmodule

// File: rtl/layer1_sequencer.sv
// layer1_sequencer
//   Walks every hidden neuron over all pixels for one image, issuing
//   pixel/weight read addresses, waiting for the accumulator's add_bias
//   and strobing store_en so downstream logic captures weighted_sum.
//   Ports:
//     clk, reset_b          clock, async active-low reset
//     start                 begin one image (ignored while busy)
//     add_bias              accumulator completion pulse
//     pixel_addr/weight_addr  memory read addresses
//     start_multiply        product-valid qualifier (addresses + 1 cycle)
//     neuron_idx            neuron being computed
//     store_en/store_idx    one-cycle capture strobe and its neuron
//     busy, done            activity flag, end-of-image pulse
//     err_timeout           sticky: add_bias missing for TIMEOUT cycles
//     err_protocol          sticky: add_bias seen outside WAIT
module layer1_sequencer #(
    parameter int NPIXEL     = layer1_sequencer_pkg::NPIXEL,
    parameter int NNEURON    = layer1_sequencer_pkg::NNEURON,
    parameter int COUNT_BIT1 = layer1_sequencer_pkg::COUNT_BIT1,
    parameter int NEURON_BIT = layer1_sequencer_pkg::NEURON_BIT,
    parameter int WADDR_BITS = layer1_sequencer_pkg::WADDR_BITS,
    parameter int TIMEOUT    = layer1_sequencer_pkg::TIMEOUT
) (
    input  logic                  clk,
    input  logic                  reset_b,
    input  logic                  start,
    input  logic                  add_bias,
    output logic [COUNT_BIT1-1:0] pixel_addr,
    output logic [WADDR_BITS-1:0] weight_addr,
    output logic                  start_multiply,
    output logic [NEURON_BIT-1:0] neuron_idx,
    output logic                  store_en,
    output logic [NEURON_BIT-1:0] store_idx,
    output logic                  busy,
    output logic                  done,
    output logic                  err_timeout,
    output logic                  err_protocol
);
    import layer1_sequencer_pkg::*;

    localparam int TW = $clog2(TIMEOUT + 1);

    seq_state_t    state;
    logic [TW-1:0] tcnt;
    logic          last_pix;
    logic          last_neuron;
    logic          issue;
    logic          clear;
    logic          step;
    logic          next_row;

    assign last_neuron = (neuron_idx == NEURON_BIT'(NNEURON - 1));
    assign issue       = (state == S_RUN);
    assign clear       = (state == S_IDLE) && start;
    assign step        = issue && !last_pix;
    assign next_row    = (state == S_STORE) && !last_neuron;

    seq_addr_gen #(
        .NPIXEL     (NPIXEL),
        .COUNT_BIT1 (COUNT_BIT1),
        .WADDR_BITS (WADDR_BITS)
    ) u_addr (
        .clk            (clk),
        .reset_b        (reset_b),
        .clear          (clear),
        .step           (step),
        .next_row       (next_row),
        .issue          (issue),
        .pixel_addr     (pixel_addr),
        .weight_addr    (weight_addr),
        .start_multiply (start_multiply),
        .last_pix       (last_pix)
    );

    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            state        <= S_IDLE;
            tcnt         <= '0;
            neuron_idx   <= '0;
            store_en     <= 1'b0;
            store_idx    <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
            err_timeout  <= 1'b0;
            err_protocol <= 1'b0;
        end else begin
            store_en <= 1'b0;
            done     <= 1'b0;
            case (state)
                S_IDLE: if (start) begin
                    state        <= S_RUN;
                    busy         <= 1'b1;
                    neuron_idx   <= '0;
                    err_timeout  <= 1'b0;
                    err_protocol <= 1'b0;
                end
                S_RUN: if (last_pix) begin
                    state <= S_WAIT;
                    tcnt  <= '0;
                end
                // add_bias is tested first so it wins over a same-cycle expiry.
                S_WAIT: if (add_bias) begin
                    state     <= S_STORE;
                    store_en  <= 1'b1;
                    store_idx <= neuron_idx;
                end else if (tcnt == TW'(TIMEOUT - 1)) begin
                    state       <= S_IDLE;
                    busy        <= 1'b0;
                    err_timeout <= 1'b1;
                end else begin
                    tcnt <= tcnt + TW'(1);
                end
                S_STORE: if (last_neuron) begin
                    state <= S_DONE;
                    done  <= 1'b1;
                    busy  <= 1'b0;
                end else begin
                    state      <= S_RUN;
                    neuron_idx <= neuron_idx + NEURON_BIT'(1);
                end
                S_DONE:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
            // Placed after the IDLE clear so a start-cycle add_bias still flags.
            if (add_bias && (state != S_WAIT))
                err_protocol <= 1'b1;
        end
    end

endmodule

// File: tb/tb_layer1_sequencer.sv
module tb_layer1_sequencer;
    localparam int NP = 4;
    localparam int NN = 3;
    localparam int CB = 10;
    localparam int NB = 4;
    localparam int WB = 14;
    localparam int TO = 16;

    logic          clk = 1'b0;
    logic          reset_b = 1'b0;
    logic          start = 1'b0;
    logic          acc_bias = 1'b0;
    logic          spur_bias = 1'b0;
    logic          add_bias;
    logic [CB-1:0] pixel_addr;
    logic [WB-1:0] weight_addr;
    logic          start_multiply;
    logic [NB-1:0] neuron_idx;
    logic          store_en;
    logic [NB-1:0] store_idx;
    logic          busy;
    logic          done;
    logic          err_timeout;
    logic          err_protocol;

    assign add_bias = acc_bias | spur_bias;

    layer1_sequencer #(
        .NPIXEL(NP), .NNEURON(NN), .COUNT_BIT1(CB),
        .NEURON_BIT(NB), .WADDR_BITS(WB), .TIMEOUT(TO)
    ) dut (
        .clk(clk), .reset_b(reset_b), .start(start), .add_bias(add_bias),
        .pixel_addr(pixel_addr), .weight_addr(weight_addr),
        .start_multiply(start_multiply), .neuron_idx(neuron_idx),
        .store_en(store_en), .store_idx(store_idx), .busy(busy), .done(done),
        .err_timeout(err_timeout), .err_protocol(err_protocol)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    typedef struct packed {
        logic [CB-1:0] pix;
        logic [WB-1:0] wa;
    } prod_t;

    prod_t         exp_prod[$];
    int            exp_store[$];
    int            done_cnt = 0;
    int            store_cnt = 0;
    logic [CB-1:0] pix_d = '0;
    logic [WB-1:0] wa_d = '0;

    // accumulator model: add_bias acc_gap negedges after start_multiply falls
    bit   acc_en = 1'b1;
    int   acc_gap = 1;
    int   acc_cnt = 0;
    logic sm_prev = 1'b0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Scoreboard + accumulator model, sampled on the falling edge.
    prod_t e;
    int    es;
    always @(negedge clk) begin
        if (reset_b) begin
            // valid data reaching the datapath belongs to last cycle's address
            if (start_multiply) begin
                if (exp_prod.size() == 0) chk("unexpected_product", 1, 0);
                else begin
                    e = exp_prod.pop_front();
                    chk("pixel_addr", 32'(pix_d), 32'(e.pix));
                    chk("weight_addr", 32'(wa_d), 32'(e.wa));
                end
            end
            if (store_en) begin
                store_cnt++;
                if (exp_store.size() == 0) chk("unexpected_store", 1, 0);
                else begin
                    es = exp_store.pop_front();
                    chk("store_idx", 32'(store_idx), es);
                end
            end
            if (done) done_cnt++;
        end
        pix_d = pixel_addr;
        wa_d  = weight_addr;
        acc_bias = 1'b0;
        if (!reset_b) begin
            acc_cnt = 0;
        end else begin
            if (acc_cnt > 0) begin
                acc_cnt--;
                if (acc_cnt == 0) acc_bias = acc_en;
            end
            if (sm_prev && !start_multiply) acc_cnt = acc_gap;
        end
        sm_prev = start_multiply;
    end

    task automatic push_image(input int nprod, input int nstore);
        for (int n = 0; n < nprod; n++)
            for (int p = 0; p < NP; p++)
                exp_prod.push_back('{pix: CB'(p), wa: WB'(n * NP + p)});
        for (int s = 0; s < nstore; s++) exp_store.push_back(s);
    endtask

    // called on a negedge; returns on the negedge after the accepting edge
    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // which: 0 = done, 1 = err_timeout; cycles counted from the start edge
    task automatic wait_evt(input string tag, input int which, input int cyc0, input int exp_cyc);
        int cyc;
        cyc = cyc0;
        while (!((which == 0) ? done : err_timeout) && cyc < exp_cyc + 20) begin
            @(negedge clk);
            cyc++;
        end
        chk(tag, cyc, exp_cyc);
    endtask

    task automatic chk_zero_outputs(input string tag);
        chk({tag, "_pixel_addr"}, 32'(pixel_addr), 0);
        chk({tag, "_weight_addr"}, 32'(weight_addr), 0);
        chk({tag, "_start_multiply"}, 32'(start_multiply), 0);
        chk({tag, "_neuron_idx"}, 32'(neuron_idx), 0);
        chk({tag, "_store_en"}, 32'(store_en), 0);
        chk({tag, "_store_idx"}, 32'(store_idx), 0);
        chk({tag, "_busy"}, 32'(busy), 0);
        chk({tag, "_done"}, 32'(done), 0);
        chk({tag, "_err_timeout"}, 32'(err_timeout), 0);
        chk({tag, "_err_protocol"}, 32'(err_protocol), 0);
    endtask

    task automatic chk_idle_after(input string tag, input int st0, input int nst, input int dn0, input int ndn);
        @(negedge clk);
        chk({tag, "_busy"}, 32'(busy), 0);
        chk({tag, "_stores"}, store_cnt - st0, nst);
        chk({tag, "_dones"}, done_cnt - dn0, ndn);
        chk({tag, "_prod_left"}, exp_prod.size(), 0);
        chk({tag, "_store_left"}, exp_store.size(), 0);
    endtask

    // done latency: per neuron NP RUN + (gap+2) WAIT + 1 STORE, plus the start edge
    function automatic int done_lat(input int gap);
        return NN * (NP + gap + 2 + 1) + 1;
    endfunction

    int st0, dn0;

    initial begin
        // reset state
        repeat (2) @(negedge clk);
        chk_zero_outputs("reset");
        reset_b = 1'b1;
        @(negedge clk);

        // 1: full image
        st0 = store_cnt; dn0 = done_cnt;
        push_image(NN, NN);
        pulse_start();
        chk("t1_busy", 32'(busy), 1);
        wait_evt("t1_done_latency", 0, 1, done_lat(1));
        chk("t1_busy_at_done", 32'(busy), 0);
        chk_idle_after("t1", st0, NN, dn0, 1);
        chk("t1_err_timeout", 32'(err_timeout), 0);
        chk("t1_err_protocol", 32'(err_protocol), 0);

        // 2: accumulator never answers -> timeout 16 cycles after WAIT entry
        acc_en = 1'b0;
        st0 = store_cnt; dn0 = done_cnt;
        push_image(1, 0);
        pulse_start();
        wait_evt("t2_timeout_latency", 1, 1, NP + TO + 1);
        chk("t2_err_timeout", 32'(err_timeout), 1);
        chk_idle_after("t2", st0, 0, dn0, 0);
        acc_en = 1'b1;

        // 3: next start clears err_timeout
        st0 = store_cnt; dn0 = done_cnt;
        push_image(NN, NN);
        pulse_start();
        chk("t3_err_timeout_cleared", 32'(err_timeout), 0);
        wait_evt("t3_done_latency", 0, 1, done_lat(1));
        chk_idle_after("t3", st0, NN, dn0, 1);

        // 4: spurious add_bias during RUN of neuron 1
        st0 = store_cnt; dn0 = done_cnt;
        push_image(NN, NN);
        pulse_start();
        repeat (8) @(negedge clk);
        chk("t4_neuron_idx", 32'(neuron_idx), 1);
        spur_bias = 1'b1;
        @(negedge clk);
        spur_bias = 1'b0;
        chk("t4_err_protocol_set", 32'(err_protocol), 1);
        wait_evt("t4_done_latency", 0, 10, done_lat(1));
        chk_idle_after("t4", st0, NN, dn0, 1);
        chk("t4_err_protocol_sticky", 32'(err_protocol), 1);

        // 5: start re-pulsed mid-RUN is ignored
        st0 = store_cnt; dn0 = done_cnt;
        push_image(NN, NN);
        pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_evt("t5_done_latency", 0, 3, done_lat(1));
        chk_idle_after("t5", st0, NN, dn0, 1);
        chk("t5_err_protocol", 32'(err_protocol), 0);
        chk("t5_err_timeout", 32'(err_timeout), 0);

        // 6: reset during WAIT of neuron 2
        st0 = store_cnt; dn0 = done_cnt;
        push_image(NN, NN - 1);
        pulse_start();
        repeat (21) @(negedge clk);
        chk("t6_neuron_idx", 32'(neuron_idx), 2);
        chk("t6_busy", 32'(busy), 1);
        reset_b = 1'b0;
        #1;
        chk_zero_outputs("t6_reset");
        repeat (2) @(negedge clk);
        reset_b = 1'b1;
        repeat (3) @(negedge clk);
        chk_idle_after("t6", st0, NN - 1, dn0, 0);
        chk("t6_err_protocol", 32'(err_protocol), 0);

        st0 = store_cnt; dn0 = done_cnt;
        push_image(NN, NN);
        pulse_start();
        wait_evt("t6b_done_latency", 0, 1, done_lat(1));
        chk_idle_after("t6b", st0, NN, dn0, 1);

        // 7: add_bias on the same cycle the timeout would expire
        acc_gap = TO - 2;
        st0 = store_cnt; dn0 = done_cnt;
        push_image(NN, NN);
        pulse_start();
        wait_evt("t7_done_latency", 0, 1, done_lat(TO - 2));
        chk_idle_after("t7", st0, NN, dn0, 1);
        chk("t7_err_timeout", 32'(err_timeout), 0);
        chk("t7_err_protocol", 32'(err_protocol), 0);
        acc_gap = 1;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/layer1_sequencer.md
Name: layer1_sequencer

Overview:
Sequences the first-layer weighted-sum datapath across all hidden neurons for one input image. For each neuron it walks the pixel index over NPIXEL cycles and drives the pixel-buffer and weight-memory read addresses. It generates the start_multiply qualifier aligned to memory read latency, waits for the accumulator's add_bias completion, and pulses a store strobe so downstream bias/activation logic captures each neuron's weighted_sum.

Parameters:
NPIXEL, 784, pixels per image = products per neuron
NNEURON, 10, hidden neurons in layer 1
COUNT_BIT1, 10, pixel index width
NEURON_BIT, 4, neuron index width
WADDR_BITS, 14, weight memory address width (must hold NNEURON*NPIXEL-1)
TIMEOUT, 16, max cycles waited for add_bias after last product

Ports:
clk  in  1  system clock, rising edge
reset_b  in  1  asynchronous active-low reset
start  in  1  one-cycle pulse: begin one image; ignored while busy
add_bias  in  1  accumulator completion pulse: weighted_sum final
pixel_addr  out  COUNT_BIT1  pixel buffer read address
weight_addr  out  WADDR_BITS  weight memory read address = neuron*NPIXEL + pixel
start_multiply  out  1  product-valid qualifier to datapath, lags addresses by 1 cycle
neuron_idx  out  NEURON_BIT  neuron currently being computed
store_en  out  1  one-cycle strobe: capture weighted_sum for store_idx
store_idx  out  NEURON_BIT  neuron index for store_en
busy  out  1  high from accepted start until done/abort
done  out  1  one-cycle pulse after last neuron stored
err_timeout  out  1  sticky; add_bias not seen within TIMEOUT cycles
err_protocol  out  1  sticky; add_bias received outside WAIT

Behaviour:
- Clock/reset: single clock clk; reset_b asynchronous active-low. On reset: all outputs 0, state IDLE, all counters 0.
- Memory contract: pixel buffer and weight memory are synchronous-read, 1-cycle latency. start_multiply is the address-issue flag registered once, so it is high on exactly the NPIXEL cycles in which valid pixel/weight data reach the datapath.
- States: IDLE, RUN, WAIT, STORE, DONE.
- IDLE: busy=0. start=1 -> RUN; pix=0, neuron=0, weight_addr=0; err_timeout and err_protocol cleared.
- RUN: issue pixel_addr=pix and weight_addr each cycle. pix increments by 1 and weight_addr increments by 1 (running counter, no multiplier, row-major weights). When pix==NPIXEL-1 -> WAIT; pix returns to 0 while weight_addr continues.
- WAIT: timeout counter runs from 0. add_bias=1 -> STORE. Counter reaching TIMEOUT -> set err_timeout, busy=0, return to IDLE; no done pulse.
- STORE: store_en=1 for exactly one cycle with store_idx=neuron. If neuron==NNEURON-1 -> DONE; otherwise neuron++ and -> RUN.
- DONE: done=1 for one cycle, busy=0 in that cycle, -> IDLE.
- Per-neuron cycle count: NPIXEL (RUN) + WAIT cycles + 1 (STORE).
- start while busy: ignored; no state change and no error flag.
- add_bias in any state other than WAIT: ignored for sequencing; sets err_protocol.
- add_bias and timeout expiry in the same cycle: add_bias wins, -> STORE, no error.
- reset_b low mid-operation: immediate return to reset values. No store_en or done is emitted for the partial image.
- pixel_addr and weight_addr hold their last value outside RUN. Downstream must use start_multiply only.

Decomposition:
- Shared package: NPIXEL, NNEURON, COUNT_BIT1, NEURON_BIT, WADDR_BITS constants and the state encoding enum, also used by the accumulator and bias/activation stages.
- One natural sub-module, seq_addr_gen: pix and weight_addr counters plus the 1-cycle start_multiply delay register. The FSM and timeout logic stay in the top.

Test Plan:
- Config NPIXEL=4, NNEURON=3. start pulse with a model accumulator returning add_bias 2 cycles after start_multiply falls -> weight_addr sequence 0..11, pixel_addr 0,1,2,3 repeated 3 times. start_multiply high for 4 cycles per neuron, starting 1 cycle after each address burst. store_en with store_idx 0,1,2. done once; busy low afterward.
- Timeout: model never returns add_bias, TIMEOUT=16 -> err_timeout=1 exactly 16 cycles after entering WAIT for neuron 0. busy=0, no store_en, no done. Next start clears err_timeout.
- Spurious add_bias during RUN of neuron 1 -> err_protocol=1. Sequencing unaffected; all 3 stores and done still occur.
- start pulsed again mid-RUN -> ignored; address sequence and done timing identical to the first test.
- reset_b asserted during WAIT of neuron 2 -> all outputs 0 immediately, no store_en for idx 2, no done. Subsequent start produces the full first-test sequence.
- add_bias coincident with the timeout expiry cycle -> STORE taken, err_timeout remains 0.
